// File: rtl/la_bist_pkg.sv
// ---------------------------------------------------------------------------
// la_bist_pkg
// Shared definitions for the logic-cell BIST engine: FSM state encoding,
// pattern sizing, golden-function codes, the expected-value pipeline entry
// and the golden-function helper used to build expected values.
// ---------------------------------------------------------------------------
package la_bist_pkg;

  localparam int PATW = 5;
  localparam int NPAT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  typedef enum logic {
    FN_OA221 = 1'b0,
    FN_AO221 = 1'b1
  } func_code_t;

  // One slot of the expected-value delay line.
  typedef struct packed {
    logic            valid;
    logic            expected;
    logic [PATW-1:0] index;
  } pipe_entry_t;

  // Golden output for a pattern laid out as {c0,b1,b0,a1,a0}.
  function automatic logic golden_z(input func_code_t fn, input logic [PATW-1:0] pat);
    logic a0, a1, b0, b1, c0;
    a0 = pat[0];
    a1 = pat[1];
    b0 = pat[2];
    b1 = pat[3];
    c0 = pat[4];
    if (fn == FN_AO221) return (a0 & a1) | (b0 & b1) | c0;
    return (a0 | a1) & (b0 | b1) & c0;
  endfunction

endpackage

// File: rtl/la_bist_pipe.sv
// ---------------------------------------------------------------------------
// la_bist_pipe
// LAT-deep delay line carrying {valid, expected, index} from pattern launch
// to the compare point. A synchronous clear empties every stage.
// Ports:
//   clk   - clock
//   clear - synchronous clear of all stages (reset or abort)
//   load  - entry captured into stage 0 on each edge
//   tail  - output of stage LAT-1, the entry due for comparison
// ---------------------------------------------------------------------------
module la_bist_pipe
  import la_bist_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  pipe_entry_t load,
  output pipe_entry_t tail
);

  pipe_entry_t stage_q [LAT];

  // Shift register: stage 0 takes the newly launched pattern, every other
  // stage takes its predecessor.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= load;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail = stage_q[LAT-1];

endmodule

// File: rtl/la_oa221_bist.sv
// ---------------------------------------------------------------------------
// la_oa221_bist
// BIST engine for a 5-input OA221/AO221 gate-under-test. Sweeps all 32
// input patterns, compares the gate output LAT edges after launch against
// the golden function and reports pass/fail, a saturating mismatch count
// and the first failing pattern.
// Parameters:
//   PROP - implementation property string, carried along unused
//   FUNC - "OA221" or "AO221" golden function
//   LAT  - edges from launch to compare, legal range 1..4
//   ERRW - mismatch counter width
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start, abort           - begin sweep (IDLE/DONE), cancel sweep (RUN/DRAIN)
//   a0,a1,b0,b1,c0         - registered stimulus, {c0,b1,b0,a1,a0} = pattern
//   z                      - gate-under-test output
//   busy, done, pass       - status
//   errcnt                 - saturating mismatch count
//   firstfail, firstvalid  - first mismatching pattern and its valid flag
// ---------------------------------------------------------------------------
module la_oa221_bist
  import la_bist_pkg::*;
#(
  parameter     PROP = "DEFAULT",
  parameter     FUNC = "OA221",
  parameter int LAT  = 1,
  parameter int ERRW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic            a0,
  output logic            a1,
  output logic            b0,
  output logic            b1,
  output logic            c0,
  input  logic            z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] errcnt,
  output logic [4:0]      firstfail,
  output logic            firstvalid
);

  localparam func_code_t      FCODE    = (FUNC == "AO221") ? FN_AO221 : FN_OA221;
  localparam logic [ERRW-1:0] ERR_MAX  = '1;
  localparam logic [PATW-1:0] LAST_PAT = PATW'(NPAT - 1);

  bist_state_t     state_q, state_d;
  logic [PATW-1:0] stim_q, stim_d, next_pat;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [PATW-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            pipe_clear, mismatch, final_cmp;
  pipe_entry_t     launch, tail;

  la_bist_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .clear (reset | pipe_clear),
    .load  (launch),
    .tail  (tail)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and status registers, all loaded from the next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      stim_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      ff_q   <= '0;
      fv_q   <= 1'b0;
    end else begin
      stim_q <= stim_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
      fv_q   <= fv_d;
    end
  end

  // Next-state logic. The compare of the pipeline tail happens on the same
  // edge that launches the next pattern; the edge that compares pattern 31
  // is the one that ends the sweep, whether the FSM is still in RUN (LAT=1)
  // or already draining. Abort skips the compare so errcnt stays frozen.
  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ff_d       = ff_q;
    fv_d       = fv_q;
    launch     = '0;
    pipe_clear = 1'b0;
    next_pat   = stim_q + PATW'(1);
    mismatch   = tail.valid && (z != tail.expected);
    final_cmp  = tail.valid && (tail.index == LAST_PAT);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d         = ST_RUN;
          stim_d          = '0;
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          err_d           = '0;
          ff_d            = '0;
          fv_d            = 1'b0;
          launch.valid    = 1'b1;
          launch.expected = golden_z(FCODE, '0);
          launch.index    = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (abort) begin
          state_d    = ST_IDLE;
          stim_d     = '0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          pipe_clear = 1'b1;
        end else begin
          if (mismatch) begin
            err_d = (err_q == ERR_MAX) ? err_q : err_q + ERRW'(1);
            if (!fv_q) begin
              ff_d = tail.index;
              fv_d = 1'b1;
            end
          end
          if (state_q == ST_RUN && stim_q != LAST_PAT) begin
            stim_d          = next_pat;
            launch.valid    = 1'b1;
            launch.expected = golden_z(FCODE, next_pat);
            launch.index    = next_pat;
          end else begin
            stim_d = '0;
            if (state_q == ST_RUN) state_d = ST_DRAIN;
          end
          if (final_cmp) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign {c0, b1, b0, a1, a0} = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign errcnt     = err_q;
  assign firstfail  = ff_q;
  assign firstvalid = fv_q;

endmodule

// File: tb/tb_la_oa221_bist.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_la_oa221_bist
// Three engines run side by side: OA221/LAT1/ERRW6, AO221/LAT2/ERRW6 and
// OA221/LAT4/ERRW3, each driving a behavioural gate-under-test with a
// selectable fault. A sweep-level reference model predicts every output.
// ---------------------------------------------------------------------------
module tb_la_oa221_bist;

  localparam int NDUT     = 3;
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DONE  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_v [NDUT];
  logic       abort_v [NDUT];
  logic       z_v     [NDUT];
  logic [4:0] stim_v  [NDUT];
  logic       busy_v  [NDUT];
  logic       done_v  [NDUT];
  logic       pass_v  [NDUT];
  logic       fv_v    [NDUT];
  logic [5:0] err_v   [NDUT];
  logic [4:0] ff_v    [NDUT];

  int          fault_mode [NDUT];
  logic [31:0] fault_mask [NDUT];

  int m_phase [NDUT];
  int m_t     [NDUT];
  int m_err   [NDUT];
  int m_ff    [NDUT];
  bit m_fv    [NDUT];

  int n_checks  = 0;
  int n_fail    = 0;
  int n_printed = 0;
  int z1_ones   = 0;
  bit count_en  = 1'b0;
  int sweep_lat [NDUT];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  function automatic int errw_of(input int g);
    return (g == 2) ? 3 : 6;
  endfunction

  // Golden truth tables written straight from the boolean definitions.
  function automatic bit golden_ref(input int g, input int p);
    if (g == 1) return ((p & 3) == 3) || ((p & 12) == 12) || ((p & 16) != 0);
    return ((p & 3) != 0) && ((p & 12) != 0) && ((p & 16) != 0);
  endfunction

  // Gate-under-test behaviour: 0 ideal, 1 c0 stuck-at-1, 2 inverted, 3 random flips.
  function automatic bit gut_bit(input int g, input int p);
    case (fault_mode[g])
      1:       return golden_ref(g, p | 16);
      2:       return !golden_ref(g, p);
      3:       return golden_ref(g, p) ^ fault_mask[g][p];
      default: return golden_ref(g, p);
    endcase
  endfunction

  // Results after patterns 0..upto have been compared.
  function automatic void sweep_stats(input int g, input int upto,
                                      output int err, output int ff, output bit fv);
    int sat;
    sat = (1 << errw_of(g)) - 1;
    err = 0;
    ff  = 0;
    fv  = 1'b0;
    for (int p = 0; p <= upto && p < 32; p++) begin
      if (gut_bit(g, p) != golden_ref(g, p)) begin
        if (!fv) begin
          ff = p;
          fv = 1'b1;
        end
        if (err < sat) err++;
      end
    end
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L  = lat_of(g);
    localparam int EW = errw_of(g);
    localparam     FN = (g == 1) ? "AO221" : "OA221";

    logic          a0, a1, b0, b1, c0, z, gut_now;
    logic          busy, done, pass, fvalid;
    logic [EW-1:0] ec;
    logic [4:0]    ff;
    logic [3:0]    zsh;

    la_oa221_bist #(.PROP("TB"), .FUNC(FN), .LAT(L), .ERRW(EW)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .abort      (abort_v[g]),
      .a0         (a0),
      .a1         (a1),
      .b0         (b0),
      .b1         (b1),
      .c0         (c0),
      .z          (z),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .errcnt     (ec),
      .firstfail  (ff),
      .firstvalid (fvalid)
    );

    // Gate model: combinational for LAT=1, LAT-1 register stages otherwise.
    always_comb gut_now = gut_bit(g, int'({c0, b1, b0, a1, a0}));
    always @(posedge clk) zsh <= {zsh[2:0], gut_now};
    assign z = (L == 1) ? gut_now : zsh[(L > 1) ? L - 2 : 0];

    assign z_v[g]    = z;
    assign stim_v[g] = {c0, b1, b0, a1, a0};
    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign pass_v[g] = pass;
    assign fv_v[g]   = fvalid;
    assign err_v[g]  = 6'(ec);
    assign ff_v[g]   = ff;
  end

  // Reference model: tracks each engine as idle / sweeping (t edges since
  // start) / done, and derives the result registers from the set of
  // patterns whose compare edge has passed.
  always @(posedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      int e, f, nt;
      bit v;
      if (reset) begin
        m_phase[g] <= PH_IDLE;
        m_t[g]     <= 0;
        m_err[g]   <= 0;
        m_ff[g]    <= 0;
        m_fv[g]    <= 1'b0;
      end else if (m_phase[g] == PH_RUN) begin
        if (abort_v[g]) begin
          m_phase[g] <= PH_IDLE;
        end else begin
          nt = m_t[g] + 1;
          sweep_stats(g, nt - lat_of(g), e, f, v);
          m_t[g]   <= nt;
          m_err[g] <= e;
          m_ff[g]  <= f;
          m_fv[g]  <= v;
          if (nt == 31 + lat_of(g)) m_phase[g] <= PH_DONE;
        end
      end else if (start_v[g] && !abort_v[g]) begin
        m_phase[g] <= PH_RUN;
        m_t[g]     <= 0;
        m_err[g]   <= 0;
        m_ff[g]    <= 0;
        m_fv[g]    <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input int g, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_printed < 40) begin
        n_printed++;
        $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, g, $time, got, exp);
      end
    end
  endtask

  // Per-cycle comparison of every engine against the reference model.
  task automatic compareAll();
    for (int g = 0; g < NDUT; g++) begin
      bit run, fin;
      run = (m_phase[g] == PH_RUN);
      fin = (m_phase[g] == PH_DONE);
      checkOutput("stim",       g, int'(stim_v[g]), (run && m_t[g] <= 31) ? m_t[g] : 0);
      checkOutput("busy",       g, int'(busy_v[g]), int'(run));
      checkOutput("done",       g, int'(done_v[g]), int'(fin));
      checkOutput("pass",       g, int'(pass_v[g]), int'(fin && m_err[g] == 0));
      checkOutput("errcnt",     g, int'(err_v[g]),  m_err[g]);
      checkOutput("firstfail",  g, int'(ff_v[g]),   m_ff[g]);
      checkOutput("firstvalid", g, int'(fv_v[g]),   int'(m_fv[g]));
    end
    if (count_en && m_phase[1] == PH_RUN && m_t[1] >= lat_of(1) - 1 && z_v[1] === 1'b1)
      z1_ones++;
  endtask

  task automatic applyStimulus(input bit r, input bit [NDUT-1:0] s, input bit [NDUT-1:0] a);
    reset = r;
    for (int g = 0; g < NDUT; g++) begin
      start_v[g] = s[g];
      abort_v[g] = a[g];
    end
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  // Start all engines together and record how many edges after the start
  // edge each one raises done; bounded so a stuck engine cannot hang the run.
  task automatic runSweep();
    bit all_done;
    applyStimulus(1'b0, '1, '0);
    for (int g = 0; g < NDUT; g++) sweep_lat[g] = -1;
    for (int e = 1; e < 200; e++) begin
      all_done = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (done_v[g] === 1'b1 && sweep_lat[g] < 0) sweep_lat[g] = e - 1;
        if (sweep_lat[g] < 0) all_done = 1'b0;
      end
      if (all_done) break;
      applyStimulus(1'b0, '0, '0);
    end
    for (int g = 0; g < NDUT; g++)
      if (sweep_lat[g] < 0) checkOutput("sweep_timeout", g, 0, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      start_v[g]    = 1'b0;
      abort_v[g]    = 1'b0;
      fault_mode[g] = 0;
      fault_mask[g] = '0;
    end
    @(negedge clk);
    applyStimulus(1'b1, '0, '0);
    applyStimulus(1'b1, '0, '0);
    checkOutput("rst_busy",   0, int'(busy_v[0]), 0);
    checkOutput("rst_errcnt", 2, int'(err_v[2]),  0);
    checkOutput("rst_stim",   1, int'(stim_v[1]), 0);
    applyStimulus(1'b0, '0, '0);

    $display("[TB] ideal sweep");
    z1_ones  = 0;
    count_en = 1'b1;
    runSweep();
    count_en = 1'b0;
    checkOutput("done_latency", 0, sweep_lat[0], 32);
    checkOutput("done_latency", 1, sweep_lat[1], 33);
    checkOutput("done_latency", 2, sweep_lat[2], 35);
    checkOutput("ideal_pass",   0, int'(pass_v[0]), 1);
    checkOutput("ideal_fv",     0, int'(fv_v[0]),   0);
    checkOutput("ideal_pass",   1, int'(pass_v[1]), 1);
    checkOutput("ao221_ones",   1, z1_ones, 23);
    applyStimulus(1'b0, '0, '0);

    $display("[TB] faulty gates");
    fault_mode[0] = 1;
    fault_mode[1] = 3;
    fault_mode[2] = 2;
    fault_mask[1] = $urandom;
    runSweep();
    checkOutput("stuck_errcnt",    0, int'(err_v[0]), 9);
    checkOutput("stuck_firstfail", 0, int'(ff_v[0]),  5);
    checkOutput("stuck_pass",      0, int'(pass_v[0]), 0);
    checkOutput("inv_errcnt",      2, int'(err_v[2]), 7);
    checkOutput("inv_firstfail",   2, int'(ff_v[2]),  0);
    checkOutput("inv_fv",          2, int'(fv_v[2]),  1);

    $display("[TB] abort at E10, stray start at E5");
    applyStimulus(1'b0, '1, '0);
    for (int e = 1; e <= 9; e++) applyStimulus(1'b0, (e == 5) ? '1 : '0, '0);
    applyStimulus(1'b0, '0, '1);
    checkOutput("abort_busy",   0, int'(busy_v[0]), 0);
    checkOutput("abort_done",   0, int'(done_v[0]), 0);
    checkOutput("abort_stim",   0, int'(stim_v[0]), 0);
    checkOutput("abort_errcnt", 0, int'(err_v[0]),  3);
    for (int g = 0; g < NDUT; g++) fault_mode[g] = 0;
    runSweep();
    checkOutput("clean_pass",   0, int'(pass_v[0]), 1);
    checkOutput("clean_errcnt", 2, int'(err_v[2]),  0);

    $display("[TB] reset at E15 with start and abort");
    applyStimulus(1'b0, '1, '0);
    for (int e = 1; e <= 14; e++) applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, '1, '1);
    for (int e = 0; e < 5; e++) applyStimulus(1'b0, '1, '1);
    checkOutput("rst_mid_busy",   1, int'(busy_v[1]), 0);
    checkOutput("rst_mid_done",   1, int'(done_v[1]), 0);
    checkOutput("rst_mid_errcnt", 0, int'(err_v[0]),  0);
    checkOutput("rst_mid_stim",   2, int'(stim_v[2]), 0);

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit [NDUT-1:0] s, a;
      bit r;
      for (int g = 0; g < NDUT; g++) begin
        if (m_phase[g] != PH_RUN && $urandom_range(0, 7) == 0) begin
          fault_mode[g] = int'($urandom_range(0, 3));
          fault_mask[g] = $urandom;
        end
        s[g] = ($urandom_range(0, 5) == 0);
        a[g] = ($urandom_range(0, 59) == 0);
      end
      r = ($urandom_range(0, 799) == 0);
      applyStimulus(r, s, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
